// File: rtl/minilab0_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minilab0_pkg
//  Purpose  : Shared sizing constants, the controller state encoding, the
//             blank-digit constant and the seven-segment hex decoder.
//  Revision : 1.0  initial release
// ============================================================================
package minilab0_pkg;

   localparam int DEPTH      = 8;
   localparam int DATA_WIDTH = 8;
   localparam int ACC_WIDTH  = 24;

   localparam logic [6:0] HEX_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Active-low segments, bit6=g ... bit0=a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/minilab0_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fifo
//  Purpose  : Show-ahead synchronous FIFO. rdata always presents the entry at
//             the read pointer. full/empty come from an occupancy counter.
//  Ports    : clk, rst_n (async, active-low)
//             wr_en/wdata : push (ignored when full)
//             rd_en       : pop  (ignored when empty; rdata is then stale)
//             rdata       : head entry
//             full, empty : occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module fifo #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  do_wr;
   logic                  do_rd;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;
   assign rdata = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/minilab0.sv
`default_nettype none
// ============================================================================
//  Module   : minilab0
//  Purpose  : DE1-SoC top. Self-loads two FIFOs with A=i+1 and B=i+11, then
//             drains them through a multiply-accumulate and shows the
//             accumulated dot product on HEX5..HEX0.
//  Ports    : CLOCK_50            functional clock
//             CLOCK2/3/4_50       unused
//             KEY[0]              async active-low reset; KEY[3:1] unused
//             SW[0]               display enable; SW[9:1] unused
//             LEDR                {5'b0, A empty, A full, DONE, EXEC, FILL}
//             HEX0..HEX5          active-low segment digits, HEX0 = LS nibble
//  Revision : 1.0  initial release
// ============================================================================
module minilab0 #(
   parameter int DEPTH      = minilab0_pkg::DEPTH,
   parameter int DATA_WIDTH = minilab0_pkg::DATA_WIDTH,
   parameter int ACC_WIDTH  = minilab0_pkg::ACC_WIDTH
) (
   input  logic       CLOCK_50,
   input  logic       CLOCK2_50,
   input  logic       CLOCK3_50,
   input  logic       CLOCK4_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   import minilab0_pkg::*;

   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

   logic                    clk;
   logic                    rst_n;
   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [ACC_WIDTH-1:0]    acc, acc_nxt;
   logic                    wr_en, rd_en;
   logic [DATA_WIDTH-1:0]   wdata_a, wdata_b;
   logic [DATA_WIDTH-1:0]   rdata_a, rdata_b;
   logic [2*DATA_WIDTH-1:0] prod;
   logic                    a_full, a_empty, b_full, b_empty;
   logic                    show;
   logic [23:0]             disp;
   logic [6:0]              seg [6];
   logic                    unused_ok;

   assign clk   = CLOCK_50;
   assign rst_n = KEY[0];

   assign unused_ok = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY[3:1], SW[9:1],
                        b_full, b_empty};

   // Operands derive from the fill counter.
   assign wdata_a = DATA_WIDTH'(cnt) + DATA_WIDTH'(1);
   assign wdata_b = DATA_WIDTH'(cnt) + DATA_WIDTH'(11);
   assign prod    = rdata_a * rdata_b;

   fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_a (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .wdata (wdata_a),
      .rdata (rdata_a),
      .full  (a_full),
      .empty (a_empty)
   );

   fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo_b (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .wdata (wdata_b),
      .rdata (rdata_b),
      .full  (b_full),
      .empty (b_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         cnt   <= '0;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         acc   <= acc_nxt;
      end
   end

   // The same counter paces both the fill and the drain phases.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc_nxt   = acc;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      case (state)
         FILL: begin
            wr_en = 1'b1;
            if (cnt == LAST_CNT) begin
               state_nxt = EXEC;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         EXEC: begin
            rd_en   = 1'b1;
            acc_nxt = acc + ACC_WIDTH'(prod);
            if (cnt == LAST_CNT) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = FILL;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign LEDR = {5'b0, a_empty, a_full,
                  state == DONE, state == EXEC, state == FILL};

   assign show = (state == DONE) && SW[0];
   assign disp = 24'(acc);

   for (genvar n = 0; n < 6; n++) begin : g_hex
      assign seg[n] = show ? hex_to_seg(disp[4*n +: 4]) : HEX_BLANK;
   end

   assign HEX0 = seg[0];
   assign HEX1 = seg[1];
   assign HEX2 = seg[2];
   assign HEX3 = seg[3];
   assign HEX4 = seg[4];
   assign HEX5 = seg[5];

endmodule
`default_nettype wire

// File: tb/tb_minilab0.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minilab0
//  Purpose  : Self-checking bench for minilab0: vector table over the fill /
//             drain timeline plus directed display, reset and hold sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_minilab0;

   logic       clk = 1'b0;
   logic [3:0] key = 4'b0000;
   logic [9:0] sw  = 10'b0;
   logic [9:0] ledr;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

   int checks = 0;
   int errors = 0;
   int e      = 0;

   always #5 clk = ~clk;

   minilab0 dut (
      .CLOCK_50  (clk),
      .CLOCK2_50 (1'b0),
      .CLOCK3_50 (1'b0),
      .CLOCK4_50 (1'b0),
      .KEY       (key),
      .SW        (sw),
      .LEDR      (ledr),
      .HEX0      (hex0),
      .HEX1      (hex1),
      .HEX2      (hex2),
      .HEX3      (hex3),
      .HEX4      (hex4),
      .HEX5      (hex5)
   );

   typedef struct {
      int          edge_n;
      logic [9:0]  ledr;
      logic [23:0] acc;
      logic [6:0]  h0, h1, h2, hhi;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic chk_all(input string tag, input logic [9:0] l, input logic [23:0] a,
                          input logic [6:0] h0, input logic [6:0] h1,
                          input logic [6:0] h2, input logic [6:0] hhi);
      chk({tag, "_ledr"}, 64'(ledr), 64'(l));
      chk({tag, "_acc"},  64'(dut.acc), 64'(a));
      chk({tag, "_hex0"}, 64'(hex0), 64'(h0));
      chk({tag, "_hex1"}, 64'(hex1), 64'(h1));
      chk({tag, "_hex2"}, 64'(hex2), 64'(h2));
      chk({tag, "_hex345"}, 64'({hex3, hex4, hex5}), 64'({hhi, hhi, hhi}));
   endtask

   // Hold reset for n cycles then release; e counts edges since release.
   task automatic do_reset(input int n);
      key[0] = 1'b0;
      repeat (n) tick();
      key[0] = 1'b1;
      e = 0;
   endtask

   initial begin
      // Partial sums of k*(k+10): 11,35,74,130,205,301,420,564 (0x234).
      vecs[0] = '{0,  10'h011, 24'd0,   7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[1] = '{1,  10'h001, 24'd0,   7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[2] = '{7,  10'h001, 24'd0,   7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[3] = '{8,  10'h00A, 24'd0,   7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[4] = '{9,  10'h002, 24'd11,  7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[5] = '{10, 10'h002, 24'd35,  7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[6] = '{12, 10'h002, 24'd130, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[7] = '{15, 10'h002, 24'd420, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      vecs[8] = '{16, 10'h014, 24'd564, 7'h19, 7'h30, 7'h24, 7'h40};
      vecs[9] = '{20, 10'h014, 24'd564, 7'h19, 7'h30, 7'h24, 7'h40};

      // Reset held: FILL with FIFO A empty, display blank.
      sw = 10'b1;
      key = 4'b0000;
      repeat (3) tick();
      chk_all("reset", 10'h011, 24'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

      // Full timeline with display enabled.
      key[0] = 1'b1;
      e = 0;
      for (int v = 0; v < 10; v++) begin
         while (e < vecs[v].edge_n) tick();
         chk_all($sformatf("vec_e%0d", vecs[v].edge_n), vecs[v].ledr, vecs[v].acc,
                 vecs[v].h0, vecs[v].h1, vecs[v].h2, vecs[v].hhi);
      end

      // DONE with display off, then on: digits appear without a clock edge.
      sw[0] = 1'b0;
      #1;
      chk_all("done_sw0", 10'h014, 24'd564, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      sw[0] = 1'b1;
      #1;
      chk_all("done_sw1", 10'h014, 24'd564, 7'h19, 7'h30, 7'h24, 7'h40);

      // Abort mid-EXEC at edge 12, then rerun to completion.
      do_reset(2);
      while (e < 12) tick();
      chk("pre_abort_acc", 64'(dut.acc), 64'd130);
      key[0] = 1'b0;
      #1;
      chk_all("abort", 10'h011, 24'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      tick();
      key[0] = 1'b1;
      e = 0;
      #1;
      chk("abort_rel_fill", 64'(ledr[0]), 64'd1);
      chk("abort_rel_acc", 64'(dut.acc), 64'd0);
      repeat (16) tick();
      chk_all("rerun", 10'h014, 24'd564, 7'h19, 7'h30, 7'h24, 7'h40);

      // DONE is terminal; ignored inputs must not disturb anything.
      for (int c = 0; c < 100; c++) begin
         key[3:1] = 3'($urandom_range(0, 7));
         sw[9:1]  = 9'($urandom_range(0, 511));
         tick();
         chk("hold_ledr", 64'(ledr), 64'h014);
         chk("hold_acc", 64'(dut.acc), 64'd564);
         chk("hold_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
             64'({7'h40, 7'h40, 7'h40, 7'h24, 7'h30, 7'h19}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/minilab0.md
# minilab0

Top-level FPGA-board block that self-loads two 8-entry FIFOs with fixed operand sequences, drains them through a multiply-accumulate datapath, and shows the 24-bit accumulated dot product on the six seven-segment displays. It sits directly on the DE1-SoC board pins: clock, push-buttons, switches, LEDs and HEX digits. It needs no external stimulus beyond reset.

## Interface
Parameters:
- DEPTH, 8: entries per FIFO and number of operand pairs.
- DATA_WIDTH, 8: FIFO/operand width, unsigned.
- ACC_WIDTH, 24: accumulator width, unsigned.

Ports:
- CLOCK_50  in  1  sole functional clock, rising edge.
- KEY  in  4  KEY[0] is the reset: asynchronous, active-low. KEY[3:1] are ignored.
- CLOCK2_50, CLOCK3_50, CLOCK4_50  in  1 each  unused, left unconnected internally.
- SW  in  10  SW[0] is the display enable. SW[9:1] are ignored.
- LEDR  out  10  state indicators.
- HEX0..HEX5  out  7 each  active-low segments, bit6=g … bit0=a. HEX0 is the least-significant nibble.

## Operation
- The state machine has three states: FILL, EXEC, DONE. Reset forces FILL.
- FILL:
  - The cycle counter i runs from 0 to DEPTH-1.
  - Each cycle pushes A=i+1 into FIFO A and B=i+11 into FIFO B, simultaneously.
  - When i=DEPTH-1 the machine goes to EXEC and the counter clears.
- EXEC:
  - Both FIFOs are show-ahead. Each cycle pops both and does acc <= acc + A*B.
  - The product is 2·DATA_WIDTH wide, zero-extended to ACC_WIDTH. Overflow wraps modulo 2^ACC_WIDTH.
  - After the DEPTH-th pop, both FIFOs are empty and the machine goes to DONE.
- DONE is terminal: acc holds its value. Only reset leaves DONE.
- FIFO rules:
  - A write when full is ignored. A read when empty returns stale data and does not move the pointers.
  - The controller never triggers either case.
  - Pointers wrap modulo DEPTH. full/empty are derived from a count register.
- LEDR:
  - LEDR[0]=FILL, LEDR[1]=EXEC, LEDR[2]=DONE, one-hot.
  - LEDR[3]=FIFO A full, LEDR[4]=FIFO A empty.
  - LEDR[9:5]=0.
- HEX:
  - When state==DONE and SW[0]=1, HEXn shows hex digit acc[4n+3:4n].
  - Otherwise every HEXn is 7'h7F (blank).
  - Encoding: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- With the default parameters, the expected result is Σ(k)(k+10) for k=1..8 = 564 = 24'h000234.

## Timing
- Reset is asynchronous and active-low:
  - While KEY[0]=0: state=FILL, counter=0, acc=0, FIFO pointers and counts=0.
  - Outputs during reset: LEDR=10'b0000010001 (FILL, FIFO A empty); all HEX=7'h7F.
- Edge count after KEY[0] rises:
  - Edges 1–8: writes. State becomes EXEC after edge 8, with FIFO A full (LEDR[3]=1).
  - Edges 9–16: pops and accumulates. State becomes DONE after edge 16.
- acc is final (564) when DONE is first visible. HEX responds combinationally to SW[0].
- Reset asserted mid-FILL or mid-EXEC aborts immediately: FIFOs empty, acc=0. After release the sequence restarts from edge 1.
- FIFO read data is valid in the same cycle as !empty (show-ahead). A simultaneous push and pop leaves the count unchanged; the controller does not use this case.

## Structure
- minilab0_pkg holds:
  - DEPTH, DATA_WIDTH, ACC_WIDTH.
  - The state enum {FILL, EXEC, DONE}.
  - The constant HEX_BLANK=7'h7F.
  - A function hex_to_seg(logic [3:0]) returning logic [6:0].
- One sub-module, fifo, parameterised on DEPTH and DATA_WIDTH, instantiated twice. Ports: clk, rst_n, wr_en, rd_en, wdata, rdata, full, empty.
- The MAC and the FSM live in minilab0 itself.

## Test plan
- Hold KEY[0]=0 for 3 cycles -> LEDR=10'h011; HEX0..5=7'h7F.
- Release reset with SW[0]=1 and run 16 edges -> LEDR[2]=1, acc=24'h000234; HEX0=7'h19, HEX1=7'h30, HEX2=7'h24, HEX3..5=7'h40.
- Sample after edge 8 -> LEDR[1]=1, LEDR[3]=1 (FIFO A full); after edge 9, acc=11.
- Reach DONE with SW[0]=0 -> all HEX=7'h7F. Toggle SW[0] to 1 -> digits appear in the same cycle.
- Assert KEY[0] low at edge 12 (mid-EXEC), then release -> acc=0 immediately, LEDR[0]=1. After 16 more edges, acc=564 again.
- Hold DONE for 100 cycles while toggling KEY[3:1] and SW[9:1] -> acc, LEDR and HEX unchanged.
